// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALUOp encodings, default widths and the ID/EX control bundle.
package pipe_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned FUNCT_W = 6;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // Reset and flush image: no write side effects, ALU op = add.
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(CTRL_W'(0));

  // An invalid ID slot must not be able to write anything downstream.
  function automatic ctrl_t mask_ctrl(input ctrl_t c);
    ctrl_t m;
    m = c;
    if (!c.valid) begin
      m.reg_write  = 1'b0;
      m.mem_to_reg = 1'b0;
      m.mem_read   = 1'b0;
      m.mem_write  = 1'b0;
      m.branch     = 1'b0;
      m.alu_op     = ALUOP_ADD;
    end
    return m;
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// ID-to-EX bus: hazard controls, ID-side payload and registered EX-side copies.
interface id_ex_reg_if #(
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned REG_AW = pipe_pkg::REG_AW
);
  logic              stall;
  logic              flush;

  logic              id_valid;
  logic              id_reg_write;
  logic              id_mem_to_reg;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_branch;
  logic              id_alu_src;
  logic              id_reg_dst;
  logic [1:0]        id_alu_op;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [4:0]        id_shamt;
  logic [5:0]        id_funct;

  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_to_reg;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_branch;
  logic              ex_alu_src;
  logic              ex_reg_dst;
  logic [1:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic [4:0]        ex_shamt;
  logic [5:0]        ex_funct;

  modport master (
    output stall, flush,
    output id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
           id_branch, id_alu_src, id_reg_dst, id_alu_op, id_pc4, id_rs_data,
           id_rt_data, id_imm, id_rs, id_rt, id_rd, id_shamt, id_funct,
    input  ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op, ex_pc4, ex_rs_data,
           ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
           id_branch, id_alu_src, id_reg_dst, id_alu_op, id_pc4, id_rs_data,
           id_rt_data, id_imm, id_rs, id_rt, id_rd, id_shamt, id_funct,
    output ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op, ex_pc4, ex_rs_data,
           ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct
  );

endinterface

// File: rtl/pipe_reg_ec.sv
// Generic W-bit pipeline register: async active-low reset, sync clear (priority), enable.
module pipe_reg_ec #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = W'(0);
    end else if (en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= W'(0);
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: control (masked by id_valid), data and instruction-field groups.
module id_ex_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned REG_AW = pipe_pkg::REG_AW
) (
  input logic        clk,
  input logic        rst_n,
  id_ex_reg_if.slave bus
);

  localparam int unsigned DGRP_W = 4 * DATA_W;
  localparam int unsigned FGRP_W = 3 * REG_AW + SHAMT_W + FUNCT_W;

  ctrl_t             ctrl_raw_c;
  ctrl_t             ctrl_masked_c;
  ctrl_t             ctrl_q;
  logic [DGRP_W-1:0] data_q;
  logic [FGRP_W-1:0] fld_q;
  logic              en_c;

  assign en_c = ~bus.stall;

  always_comb begin
    ctrl_raw_c            = CTRL_BUBBLE;
    ctrl_raw_c.valid      = bus.id_valid;
    ctrl_raw_c.reg_write  = bus.id_reg_write;
    ctrl_raw_c.mem_to_reg = bus.id_mem_to_reg;
    ctrl_raw_c.mem_read   = bus.id_mem_read;
    ctrl_raw_c.mem_write  = bus.id_mem_write;
    ctrl_raw_c.branch     = bus.id_branch;
    ctrl_raw_c.alu_src    = bus.id_alu_src;
    ctrl_raw_c.reg_dst    = bus.id_reg_dst;
    ctrl_raw_c.alu_op     = bus.id_alu_op;
    ctrl_masked_c         = mask_ctrl(ctrl_raw_c);
  end

  pipe_reg_ec #(.W(CTRL_W)) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (en_c),
    .clr_i (bus.flush),
    .d_i   (ctrl_masked_c),
    .q_o   (ctrl_q)
  );

  pipe_reg_ec #(.W(DGRP_W)) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (en_c),
    .clr_i (bus.flush),
    .d_i   ({bus.id_pc4, bus.id_rs_data, bus.id_rt_data, bus.id_imm}),
    .q_o   (data_q)
  );

  pipe_reg_ec #(.W(FGRP_W)) u_fld (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (en_c),
    .clr_i (bus.flush),
    .d_i   ({bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt, bus.id_funct}),
    .q_o   (fld_q)
  );

  assign bus.ex_valid      = ctrl_q.valid;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_branch     = ctrl_q.branch;
  assign bus.ex_alu_src    = ctrl_q.alu_src;
  assign bus.ex_reg_dst    = ctrl_q.reg_dst;
  assign bus.ex_alu_op     = ctrl_q.alu_op;

  assign {bus.ex_pc4, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm} = data_q;
  assign {bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_shamt, bus.ex_funct} = fld_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus randomized traffic against a reference model.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    logic        reg_dst;
    logic [1:0]  alu_op;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
  } io_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  io_t  exp_q;

  id_ex_reg_if bus ();

  id_ex_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic io_t get_id();
    io_t r;
    r = '{bus.id_valid, bus.id_reg_write, bus.id_mem_to_reg, bus.id_mem_read,
          bus.id_mem_write, bus.id_branch, bus.id_alu_src, bus.id_reg_dst,
          bus.id_alu_op, bus.id_pc4, bus.id_rs_data, bus.id_rt_data, bus.id_imm,
          bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt, bus.id_funct};
    return r;
  endfunction

  function automatic io_t get_ex();
    io_t r;
    r = '{bus.ex_valid, bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_read,
          bus.ex_mem_write, bus.ex_branch, bus.ex_alu_src, bus.ex_reg_dst,
          bus.ex_alu_op, bus.ex_pc4, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm,
          bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_shamt, bus.ex_funct};
    return r;
  endfunction

  // What EX should show after loading a given ID image.
  function automatic io_t load_rule(input io_t i);
    io_t o;
    o = i;
    if (!i.valid) begin
      o.reg_write  = 1'b0;
      o.mem_to_reg = 1'b0;
      o.mem_read   = 1'b0;
      o.mem_write  = 1'b0;
      o.branch     = 1'b0;
      o.alu_op     = 2'b00;
    end
    return o;
  endfunction

  // Reference model: reset > flush > stall > load.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         exp_q <= '0;
    else if (bus.flush) exp_q <= '0;
    else if (!bus.stall) exp_q <= load_rule(get_id());
  end

  // Every-cycle comparison of the whole EX image against the model.
  always @(negedge clk) begin
    io_t act;
    act = get_ex();
    checks = checks + 1;
    if (act !== exp_q) begin
      errors = errors + 1;
      $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act, exp_q);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    bus.id_valid = 1'b0; bus.id_reg_write = 1'b0; bus.id_mem_to_reg = 1'b0;
    bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0; bus.id_branch = 1'b0;
    bus.id_alu_src = 1'b0; bus.id_reg_dst = 1'b0; bus.id_alu_op = 2'b00;
    bus.id_pc4 = '0; bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0; bus.id_shamt = '0; bus.id_funct = '0;
  endtask

  task automatic rand_id();
    bus.id_valid      = 1'($urandom);
    bus.id_reg_write  = 1'($urandom);
    bus.id_mem_to_reg = 1'($urandom);
    bus.id_mem_read   = 1'($urandom);
    bus.id_mem_write  = 1'($urandom);
    bus.id_branch     = 1'($urandom);
    bus.id_alu_src    = 1'($urandom);
    bus.id_reg_dst    = 1'($urandom);
    bus.id_alu_op     = 2'($urandom);
    bus.id_pc4        = $urandom;
    bus.id_rs_data    = $urandom;
    bus.id_rt_data    = $urandom;
    bus.id_imm        = $urandom;
    bus.id_rs         = 5'($urandom);
    bus.id_rt         = 5'($urandom);
    bus.id_rd         = 5'($urandom);
    bus.id_shamt      = 5'($urandom);
    bus.id_funct      = 6'($urandom);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    clear_id();
    repeat (2) tick();
    chk("reset_valid", 32'(bus.ex_valid), 32'd0);
    chk("reset_pc4", bus.ex_pc4, 32'd0);

    // 1: async reset without a clock edge
    bus.id_valid = 1'b1; bus.id_reg_write = 1'b1; bus.id_mem_write = 1'b1;
    bus.id_alu_op = 2'b10; bus.id_pc4 = 32'h0000_1004; bus.id_rs_data = 32'hDEAD_BEEF;
    bus.id_imm = 32'hFFFF_FFF0; bus.id_rd = 5'd31; bus.id_funct = 6'd42; bus.id_shamt = 5'd7;
    rst_n = 1'b1;
    tick();
    chk("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
    chk("pre_rst_funct", 32'(bus.ex_funct), 32'd42);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("async_rst_rs_data", bus.ex_rs_data, 32'd0);
    chk("async_rst_alu_op", 32'(bus.ex_alu_op), 32'd0);
    chk("async_rst_rd", 32'(bus.ex_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_load_pc4", bus.ex_pc4, 32'h0000_1004);

    // 2: add $3,$1,$2
    clear_id();
    bus.id_valid = 1'b1; bus.id_alu_op = 2'b10; bus.id_funct = 6'd32; bus.id_reg_dst = 1'b1;
    bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_rd = 5'd3;
    bus.id_rs_data = 32'd5; bus.id_rt_data = 32'd7; bus.id_reg_write = 1'b1;
    tick();
    chk("add_funct", 32'(bus.ex_funct), 32'd32);
    chk("add_reg_write", 32'(bus.ex_reg_write), 32'd1);
    chk("add_rs_data", bus.ex_rs_data, 32'd5);
    chk("add_rt_data", bus.ex_rt_data, 32'd7);
    chk("add_rd", 32'(bus.ex_rd), 32'd3);
    chk("add_alu_op", 32'(bus.ex_alu_op), 32'd2);

    // 3: lw held by a 3-cycle stall while ID shows sw
    clear_id();
    bus.id_valid = 1'b1; bus.id_mem_read = 1'b1; bus.id_mem_to_reg = 1'b1;
    bus.id_reg_write = 1'b1; bus.id_alu_src = 1'b1; bus.id_imm = 32'd4;
    bus.id_rs = 5'd1; bus.id_rt = 5'd8;
    tick();
    bus.stall = 1'b1;
    bus.id_mem_read = 1'b0; bus.id_mem_to_reg = 1'b0; bus.id_reg_write = 1'b0;
    bus.id_mem_write = 1'b1; bus.id_imm = 32'd8; bus.id_rt = 5'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_mem_read", 32'(bus.ex_mem_read), 32'd1);
      chk("stall_mem_write", 32'(bus.ex_mem_write), 32'd0);
      chk("stall_imm", bus.ex_imm, 32'd4);
    end
    bus.stall = 1'b0;
    tick();
    chk("unstall_mem_write", 32'(bus.ex_mem_write), 32'd1);
    chk("unstall_imm", bus.ex_imm, 32'd8);

    // 4: beq, then flush and stall together
    clear_id();
    bus.id_valid = 1'b1; bus.id_branch = 1'b1; bus.id_alu_op = 2'b01;
    bus.id_rs_data = 32'd3; bus.id_rt_data = 32'd3; bus.id_pc4 = 32'h40; bus.id_imm = 32'd2;
    tick();
    chk("beq_branch", 32'(bus.ex_branch), 32'd1);
    bus.stall = 1'b1; bus.flush = 1'b1;
    tick();
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_branch", 32'(bus.ex_branch), 32'd0);
    chk("flush_alu_op", 32'(bus.ex_alu_op), 32'd0);
    chk("flush_rs_data", bus.ex_rs_data, 32'd0);
    chk("flush_pc4", bus.ex_pc4, 32'd0);
    chk("flush_imm", bus.ex_imm, 32'd0);
    bus.stall = 1'b0; bus.flush = 1'b0;

    // 5: invalid ID slot
    clear_id();
    bus.id_reg_write = 1'b1; bus.id_mem_write = 1'b1; bus.id_alu_op = 2'b01; bus.id_rs_data = 32'd9;
    tick();
    chk("inv_reg_write", 32'(bus.ex_reg_write), 32'd0);
    chk("inv_mem_write", 32'(bus.ex_mem_write), 32'd0);
    chk("inv_alu_op", 32'(bus.ex_alu_op), 32'd0);
    chk("inv_rs_data", bus.ex_rs_data, 32'd9);

    // 6: sub / sll back to back
    clear_id();
    bus.id_valid = 1'b1; bus.id_alu_op = 2'b10; bus.id_reg_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.id_funct = (i % 2 == 0) ? 6'd34 : 6'd0;
      bus.id_shamt = (i % 2 == 0) ? 5'd0 : 5'd4;
      tick();
      chk("b2b_funct", 32'(bus.ex_funct), (i % 2 == 0) ? 32'd34 : 32'd0);
      chk("b2b_shamt", 32'(bus.ex_shamt), (i % 2 == 0) ? 32'd0 : 32'd4);
    end

    // Randomized traffic with stalls, flushes and occasional async resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rand_id();
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline.
- Captures decoded control, register-file data, immediate and instruction fields from ID, and presents them to EX for one cycle.
- Drives the ALU control decoder directly: ex_alu_op and ex_funct are its inputs.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_W, 32, width of register data, immediate and PC+4.
- REG_AW, 5, register-specifier width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- stall  in  1  hold current contents.
- flush  in  1  load a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_reg_write  in  1  control.
- id_mem_to_reg  in  1  control.
- id_mem_read  in  1  control.
- id_mem_write  in  1  control.
- id_branch  in  1  control.
- id_alu_src  in  1  control.
- id_reg_dst  in  1  control.
- id_alu_op  in  2  00 add, 01 sub, 10 R-type.
- id_pc4  in  DATA_W  PC+4.
- id_rs_data  in  DATA_W  register-file read data, port 1.
- id_rt_data  in  DATA_W  register-file read data, port 2.
- id_imm  in  DATA_W  sign-extended immediate.
- id_rs  in  REG_AW  instruction field.
- id_rt  in  REG_AW  instruction field.
- id_rd  in  REG_AW  instruction field.
- id_shamt  in  5  instruction[10:6].
- id_funct  in  6  instruction[5:0].
- ex_*  out  (same widths)  registered copies of every id_* input, including ex_valid.

Behaviour:
- Reset: rst_n low asynchronously clears every ex_* output to 0 (ex_valid=0, ex_alu_op=2'b00, all data 0). Reset has no dependency on clk.
- Latency: exactly 1 cycle. Inputs sampled at the posedge are visible on ex_* immediately after that edge.
- Per-edge priority (highest first): reset, flush, stall, load.
- flush=1: every ex_* is cleared to 0, identical to the reset image.
  - Bubble has ex_alu_op=00 (add) and ex_funct=0.
  - No register or memory write can occur from a bubble.
- stall=1 with flush=0: all ex_* hold their values. No field changes.
- flush and stall both high: flush wins, and a bubble is loaded.
- Load with id_valid=0:
  - Control bits (reg_write, mem_to_reg, mem_read, mem_write, branch) are forced to 0, and ex_valid=0.
  - ex_alu_op is forced to 00.
  - Data and field outputs load normally.
- Load with id_valid=1: all fields copied verbatim, with no modification or width change.
- The block performs no decode: funct and shamt pass through untouched. funct=0 with alu_op=10 is a legal sll.
- Reset deassertion mid-stream: the first edge after rst_n rises performs a normal load.
- A stall held for N cycles keeps outputs constant for N edges, with no drift.

Decomposition:
- Shared package (pipe_pkg) holds:
  - ALUOp encodings ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_RTYPE=2'b10.
  - DATA_W and REG_AW defaults.
  - The bubble/reset value constant.
- These are shared with the ALU control decoder and the other pipeline registers.
- Sub-module pipe_reg_ec: a generic W-bit register with async active-low reset, enable (=!stall) and sync clear (=flush). It is instantiated per field group: control, data, fields.
- The id_valid control masking lives in id_ex_reg.

Test Plan:
1. Reset: drive all inputs nonzero, pulse rst_n low between edges -> all ex_* are 0 immediately, without waiting for a clock edge.
2. Load: id_valid=1, add $3,$1,$2 (alu_op=10, funct=32, rs=1, rt=2, rd=3, rs_data=5, rt_data=7, reg_write=1) -> after 1 edge, ex_* match, ex_funct=32, ex_reg_write=1.
3. Stall: load lw (alu_op=00, mem_read=1, imm=4), then stall=1 for 3 edges while ID changes to sw -> ex_* remain lw values on all 3 edges.
4. Flush over stall: with a beq loaded, assert stall=1 and flush=1 together -> next edge gives ex_valid=0, ex_branch=0, ex_alu_op=00, all data 0.
5. Invalid ID: id_valid=0 with reg_write=1, mem_write=1, alu_op=01, rs_data=9 -> ex_reg_write=0, ex_mem_write=0, ex_alu_op=00, ex_rs_data=9.
6. Back-to-back: alternate sub (funct 34) and sll (funct 0, shamt 4) over 4 edges -> ex_funct sequence 34,0,34,0; ex_shamt 4 on the sll cycles.
